// File: rtl/divider_ctrl.sv
// divider_ctrl: sequential restoring-division controller with partial-remainder datapath.
// Produces one quotient bit per clock, MSB first, by steering an external quotient shift
// register, and owns the remainder register and the start/done handshake.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request, sampled only while idle
//   dividend  in   numerator, captured on acceptance
//   divisor   in   denominator, captured on acceptance
//   q_load    out  clears the quotient register
//   q_mux     out  quotient register control: 01 shift in 0, 10 shift in 1, 00 hold
//   remainder out  registered partial/final remainder
//   busy      out  high from the cycle after acceptance until done is left
//   done      out  one-cycle pulse, quotient register and remainder valid
//   div_zero  out  registered flag, captured divisor was zero
module divider_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             q_load,
   output logic [1:0]       q_mux,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   typedef enum logic [1:0] {StIdle, StClear, StIter, StDone} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] d_q;
   logic [WIDTH-1:0] v_q;
   logic [WIDTH-1:0] r_q;
   logic             div_zero_q;

   // Trial value is one bit wider than R so a set R MSB cannot overflow the compare.
   logic [WIDTH:0]   trial;
   logic             trial_ge;
   logic [WIDTH-1:0] r_sub;

   assign trial    = {r_q, d_q[WIDTH-1]};
   assign trial_ge = (trial >= {1'b0, v_q});
   // When trial >= V the difference fits in WIDTH bits, so the low-half subtract is exact.
   assign r_sub    = trial[WIDTH-1:0] - v_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StClear;
         StClear: state_d = StIter;
         StIter:  if (cnt_q == CNT_W'(1)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      q_load = 1'b0;
      q_mux  = 2'b00;
      busy   = 1'b0;
      done   = 1'b0;
      unique case (state_q)
         StIdle: ;
         StClear: begin
            q_load = 1'b1;
            busy   = 1'b1;
         end
         StIter: begin
            q_mux = trial_ge ? 2'b10 : 2'b01;
            busy  = 1'b1;
         end
         StDone: begin
            done = 1'b1;
            busy = 1'b1;
         end
         default: ;
      endcase
   end

   // Operand, remainder and iteration-count datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         d_q        <= '0;
         v_q        <= '0;
         r_q        <= '0;
         div_zero_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  d_q        <= dividend;
                  v_q        <= divisor;
                  r_q        <= '0;
                  div_zero_q <= (divisor == '0);
                  cnt_q      <= CNT_W'(WIDTH);
               end
            end
            StIter: begin
               r_q   <= trial_ge ? r_sub : trial[WIDTH-1:0];
               d_q   <= {d_q[WIDTH-2:0], 1'b0};
               cnt_q <= cnt_q - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign remainder = r_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_divider_ctrl.sv
// Self-checking bench for divider_ctrl: models the downstream quotient register, keeps a
// scoreboard of expected quotient/remainder/div_zero, and checks handshake timing.
module tb_divider_ctrl;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 6;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             q_load;
   logic [1:0]       q_mux;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_zero;

   divider_ctrl #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .q_load    (q_load),
      .q_mux     (q_mux),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             dz;
   } exp_t;

   exp_t sb[$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model of the downstream quotient shift register
   logic [WIDTH-1:0] q_reg = '0;
   always @(posedge clk) begin
      if (q_load) begin
         q_reg <= '0;
      end else begin
         case (q_mux)
            2'b01:   q_reg <= {q_reg[WIDTH-2:0], 1'b0};
            2'b10:   q_reg <= {q_reg[WIDTH-2:0], 1'b1};
            default: q_reg <= q_reg;
         endcase
      end
   end

   // Per-operation activity counters, cleared whenever the DUT is not busy
   int n_load = 0;
   int n_one  = 0;
   int n_zero = 0;
   int n_both = 0;
   always @(posedge clk) begin
      if (!busy) begin
         n_load <= 0;
         n_one  <= 0;
         n_zero <= 0;
         n_both <= 0;
      end else begin
         n_load <= n_load + int'(q_load);
         n_one  <= n_one + int'(q_mux == 2'b10);
         n_zero <= n_zero + int'(q_mux == 2'b01);
         n_both <= n_both + int'(q_load && (q_mux == 2'b01 || q_mux == 2'b10));
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"}, 64'(busy), 64'd0);
      check_eq({tag, "_done"}, 64'(done), 64'd0);
      check_eq({tag, "_dz"}, 64'(div_zero), 64'd0);
      check_eq({tag, "_qload"}, 64'(q_load), 64'd0);
      check_eq({tag, "_qmux"}, 64'(q_mux), 64'd0);
      check_eq({tag, "_rem"}, 64'(remainder), 64'd0);
   endtask

   // Issue one division; optionally re-assert start with other operands mid-ITER.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit poke);
      exp_t e;
      int   acc;
      bit   seen;
      int   ones;
      e.q  = (b == '0) ? '1 : a / b;
      e.r  = (b == '0) ? a : a % b;
      e.dz = (b == '0);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      acc      = cyc + 1;  // number of the acceptance edge
      sb.push_back(e);
      @(negedge clk);
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      if (poke) begin
         repeat (5) @(negedge clk);
         dividend = 32'd1000;
         divisor  = 32'd3;
         start    = 1'b1;
         @(negedge clk);
         start    = 1'b0;
      end
      seen = 1'b0;
      for (int t = 0; t < 100; t++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check_eq("done_seen", 64'(seen), 64'd1);
      if (seen) begin
         e    = sb.pop_front();
         ones = $countones(e.q);
         check_eq("quotient", 64'(q_reg), 64'(e.q));
         check_eq("remainder", 64'(remainder), 64'(e.r));
         check_eq("div_zero", 64'(div_zero), 64'(e.dz));
         // DONE begins at edge acc + 1 (CLEAR) + WIDTH (ITER)
         check_eq("latency", 64'(cyc - acc), 64'(WIDTH + 1));
         check_eq("busy_in_done", 64'(busy), 64'd1);
         check_eq("qload_cycles", 64'(n_load), 64'd1);
         check_eq("shift1_cycles", 64'(n_one), 64'(ones));
         check_eq("shift0_cycles", 64'(n_zero), 64'(WIDTH - ones));
         check_eq("load_mux_overlap", 64'(n_both), 64'd0);
         @(negedge clk);
         check_eq("done_pulse_end", 64'(done), 64'd0);
         check_eq("busy_after_done", 64'(busy), 64'd0);
         check_eq("remainder_held", 64'(remainder), 64'(e.r));
      end else begin
         sb.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int extra_done;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      run_op(32'd100, 32'd7, 1'b0);
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
      run_op(32'd5, 32'd0, 1'b0);
      run_op(32'd9, 32'd3, 1'b0);
      run_op(32'd3, 32'd10, 1'b0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      for (int i = 0; i < 4; i++) begin
         run_op($urandom, $urandom_range(1, 70000), 1'b0);
      end

      // Start during ITER is ignored and done fires only once
      run_op(32'd100, 32'd7, 1'b1);
      extra_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      check_eq("no_extra_done", 64'(extra_done), 64'd0);

      // Asynchronous reset mid-ITER aborts at once
      @(negedge clk);
      dividend = 32'hFFFF_FFFF;
      divisor  = 32'd0;
      start    = 1'b1;
      sb.push_back('{q: '1, r: 32'hFFFF_FFFF, dz: 1'b1});
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      check_eq("dz_before_rst", 64'(div_zero), 64'd1);
      check_eq("busy_before_rst", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'd100, 32'd7, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
